// File: rtl/avmm_arb_pkg.sv
// Shared types and helpers for the two-master Avalon-MM arbiter.
package avmm_arb_pkg;

  typedef logic owner_t;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {IDLE = ST_IDLE, BUSY = ST_BUSY} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/avmm_rsp_id_fifo.sv
// Small FIFO holding the ID of the master behind each outstanding read.
module avmm_rsp_id_fifo
  import avmm_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/avmm_arb_2to1.sv
// Two-master Avalon-MM arbiter with pipelined read-response routing.
// Define AVMM_ARB_FIXED_PRIO_EN to make master 0 win every tie instead of round-robin.
module avmm_arb_2to1
  import avmm_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  input  logic                s_waitrequest,
  output logic                err_unexp_rsp
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              tie_win;
  logic                req0, req1, busy, accept;
  logic                own_read, own_write;
  logic                fifo_full, fifo_empty;
  owner_t              head;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdv0_q, rdv0_d, rdv1_q, rdv1_d;
  logic                err_q, err_d;
`ifndef AVMM_ARB_FIXED_PRIO_EN
  owner_t              last_q, last_d;
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign busy = (state_q == BUSY);

`ifdef AVMM_ARB_FIXED_PRIO_EN
  assign tie_win = 1'b0;
`else
  assign tie_win = ~last_q;
`endif

  // Command fields always follow the owner; only the strobes are gated by state.
  assign own_read     = owner_q ? m1_read       : m0_read;
  assign own_write    = owner_q ? m1_write      : m0_write;
  assign s_address    = owner_q ? m1_address    : m0_address;
  assign s_byteenable = owner_q ? m1_byteenable : m0_byteenable;
  assign s_writedata  = owner_q ? m1_writedata  : m0_writedata;
  assign s_write      = busy & own_write;
  assign s_read       = busy & own_read & ~own_write & ~fifo_full;
  assign accept       = (s_read | s_write) & ~s_waitrequest;

  assign m0_waitrequest = ~(accept & (owner_q == 1'b0));
  assign m1_waitrequest = ~(accept & (owner_q == 1'b1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifndef AVMM_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: if (req0 | req1) begin
        owner_d = (req0 & req1) ? tie_win : owner_t'(req1);
        state_d = BUSY;
      end
      BUSY: if (accept) begin
`ifndef AVMM_ARB_FIXED_PRIO_EN
        last_d  = owner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A response with nothing outstanding is dropped and flagged.
  always_comb begin
    rdata_d = s_readdata;
    rdv0_d  = s_readdatavalid & ~fifo_empty & (head == 1'b0);
    rdv1_d  = s_readdatavalid & ~fifo_empty & (head == 1'b1);
    err_d   = err_q | (s_readdatavalid & fifo_empty);
  end

  avmm_rsp_id_fifo #(.DEPTH(MAX_PEND), .WIDTH(1)) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & s_read),
    .pop     (s_readdatavalid),
    .din     (owner_q),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
`ifndef AVMM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
      rdata_q <= '0;
      rdv0_q  <= 1'b0;
      rdv1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifndef AVMM_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
      rdata_q <= rdata_d;
      rdv0_q  <= rdv0_d;
      rdv1_q  <= rdv1_d;
      err_q   <= err_d;
    end
  end

  assign m0_readdata      = rdata_q;
  assign m1_readdata      = rdata_q;
  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;
  assign err_unexp_rsp    = err_q;

endmodule

// File: tb/tb_avmm_arb_2to1.sv
// Directed self-checking bench for avmm_arb_2to1.
module tb_avmm_arb_2to1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write, s_readdatavalid, s_waitrequest, err_unexp_rsp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avmm_arb_2to1 dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_waitrequest(s_waitrequest),
    .err_unexp_rsp(err_unexp_rsp)
  );

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    s_readdata = '0; s_readdatavalid = 0; s_waitrequest = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid,
         m1_readdatavalid, err_unexp_rsp} !== 7'b0011000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=0011000", {s_read, s_write, m0_waitrequest,
               m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_unexp_rsp});
    end
    checks++;
    if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_readdata got=%h/%h exp=0", m0_readdata, m1_readdata);
    end
  endtask

  // m0 write held by slave waitrequest; read also asserted to exercise write priority.
  task automatic test_write_hold;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      m0_write = (c <= 4); m0_read = (c <= 4);
      m0_address = 32'h10; m0_writedata = 32'hCAFE0001; m0_byteenable = 4'hF;
      s_waitrequest = (c <= 3);
      #1;
      checks++;
      if (c >= 1 && c <= 4) begin
        if ({s_write, s_read, s_address, s_writedata, s_byteenable} !==
            {1'b1, 1'b0, 32'h10, 32'hCAFE0001, 4'hF}) begin
          failures++;
          $display("FAIL wr_cmd c=%0d got w=%b r=%b a=%h d=%h be=%h", c, s_write, s_read,
                   s_address, s_writedata, s_byteenable);
        end
      end else if ({s_write, s_read} !== 2'b00) begin
        failures++;
        $display("FAIL wr_idle c=%0d got w=%b r=%b exp 0/0", c, s_write, s_read);
      end
      checks++;
      if ({m0_waitrequest, m1_waitrequest} !== {(c != 4), 1'b1}) begin
        failures++;
        $display("FAIL wr_wait c=%0d got=%b exp=%b", c, {m0_waitrequest, m1_waitrequest},
                 {(c != 4), 1'b1});
      end
    end
  endtask

  task automatic test_round_robin;
    int g, pg;
    pg = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m0_read = 1; m1_read = 1; m0_address = 32'h40; m1_address = 32'h44;
      s_readdatavalid = (k > 0); s_readdata = 32'h100 + k - 1;
      #1;
      checks++;
      if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
        failures++;
        $display("FAIL rr_idle k=%0d got=%b exp=011", k, {s_read, m0_waitrequest, m1_waitrequest});
      end
      @(negedge clk);
      s_readdatavalid = 0;
      #1;
`ifdef AVMM_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      checks++;
      if ({s_read, m0_waitrequest, m1_waitrequest} !== {1'b1, g != 0, g != 1}) begin
        failures++;
        $display("FAIL rr_grant k=%0d got=%b exp=%b", k, {s_read, m0_waitrequest, m1_waitrequest},
                 {1'b1, g != 0, g != 1});
      end
      if (k > 0) begin
        checks++;
        if ({m1_readdatavalid, m0_readdatavalid} !== (2'b01 << pg) ||
            m0_readdata !== 32'h100 + k - 1) begin
          failures++;
          $display("FAIL rr_rsp k=%0d got=%b/%h exp=%b/%h", k, {m1_readdatavalid, m0_readdatavalid},
                   m0_readdata, 2'b01 << pg, 32'h100 + k - 1);
        end
      end
      pg = g;
    end
    @(negedge clk);
    m0_read = 0; m1_read = 0; s_readdatavalid = 1; s_readdata = 32'h103;
    @(negedge clk);
    s_readdatavalid = 0;
    #1;
    checks++;
    if ({m1_readdatavalid, m0_readdatavalid} !== (2'b01 << pg) || m1_readdata !== 32'h103) begin
      failures++;
      $display("FAIL rr_last_rsp got=%b/%h exp=%b/103", {m1_readdatavalid, m0_readdatavalid},
               m1_readdata, 2'b01 << pg);
    end
  endtask

  // Four m1 reads fill the FIFO; the fifth waits for a pop plus one cycle.
  task automatic test_fifo_full;
    logic        prv;
    logic [31:0] pdat;
    prv = 0; pdat = '0;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      m1_read = (c <= 12); m1_address = 32'h20;
      s_readdatavalid = (c == 11) || (c >= 13 && c <= 16);
      s_readdata = 32'hD0 + ((c == 11) ? 1 : c - 11);
      #1;
      if (c == 1 || c == 3 || c == 5 || c == 7 || c == 12) begin
        checks++;
        if ({s_read, m1_waitrequest} !== 2'b10) begin
          failures++;
          $display("FAIL full_accept c=%0d got=%b exp=10", c, {s_read, m1_waitrequest});
        end
      end else if (c >= 9 && c <= 11) begin
        checks++;
        if ({s_read, m1_waitrequest, m0_waitrequest} !== 3'b011) begin
          failures++;
          $display("FAIL full_stall c=%0d got=%b exp=011", c, {s_read, m1_waitrequest, m0_waitrequest});
        end
      end else if (c <= 8) begin
        checks++;
        if ({s_read, m1_waitrequest} !== 2'b01) begin
          failures++;
          $display("FAIL full_idle c=%0d got=%b exp=01", c, {s_read, m1_waitrequest});
        end
      end
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== {1'b0, prv} || (prv && m1_readdata !== pdat)) begin
        failures++;
        $display("FAIL full_rsp c=%0d got=%b/%h exp=%b/%h", c, {m0_readdatavalid, m1_readdatavalid},
                 m1_readdata, {1'b0, prv}, pdat);
      end
      prv = s_readdatavalid; pdat = s_readdata;
    end
  endtask

  task automatic test_interleave;
    logic [1:0] exp_v;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      m0_read = (c <= 5); m0_address = (c < 2) ? 32'h0 : 32'h8;
      m1_read = (c <= 3); m1_address = 32'h4;
      s_readdatavalid = (c >= 6 && c <= 8); s_readdata = 32'hA + c - 6;
      #1;
      if (c == 1 || c == 3 || c == 5) begin
        checks++;
        if ({s_read, s_address, m0_waitrequest, m1_waitrequest} !==
            {1'b1, (c == 1) ? 32'h0 : (c == 3) ? 32'h4 : 32'h8, c == 3, c != 3}) begin
          failures++;
          $display("FAIL il_cmd c=%0d got r=%b a=%h w=%b", c, s_read, s_address,
                   {m0_waitrequest, m1_waitrequest});
        end
      end
      exp_v = (c == 7 || c == 9) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
      checks++;
      if ({m1_readdatavalid, m0_readdatavalid} !== exp_v ||
          (exp_v != 2'b00 && m0_readdata !== 32'hA + c - 7)) begin
        failures++;
        $display("FAIL il_rsp c=%0d got=%b/%h exp=%b/%h", c, {m1_readdatavalid, m0_readdatavalid},
                 m0_readdata, exp_v, 32'hA + c - 7);
      end
    end
  endtask

  task automatic test_unexpected;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      s_readdatavalid = (c == 0); s_readdata = 32'h55;
      #1;
      checks++;
      if ({err_unexp_rsp, m0_readdatavalid, m1_readdatavalid} !== {c != 0, 2'b00}) begin
        failures++;
        $display("FAIL unexp c=%0d got=%b exp=%b", c, {err_unexp_rsp, m0_readdatavalid,
                 m1_readdatavalid}, {c != 0, 2'b00});
      end
    end
  endtask

  // Reset while m1 holds the bus with two reads outstanding.
  task automatic test_mid_reset;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      m1_read = (c <= 6); m1_address = 32'h30;
      s_waitrequest = (c == 5 || c == 6);
      reset_n = (c != 6);
      s_readdatavalid = (c == 7); s_readdata = 32'h77;
      #1;
      if (c == 6) begin
        checks++;
        if ({s_read, m1_waitrequest} !== 2'b11) begin
          failures++;
          $display("FAIL mr_busy got=%b exp=11", {s_read, m1_waitrequest});
        end
      end
      if (c == 7) begin
        checks++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
             err_unexp_rsp} !== 7'b0011000 || m0_readdata !== 32'h0) begin
          failures++;
          $display("FAIL mr_after_reset got=%b/%h exp=0011000/0", {s_read, s_write, m0_waitrequest,
                   m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_unexp_rsp}, m0_readdata);
        end
      end
      if (c == 8) begin
        checks++;
        if ({err_unexp_rsp, m0_readdatavalid, m1_readdatavalid} !== 3'b100) begin
          failures++;
          $display("FAIL mr_stale got=%b exp=100", {err_unexp_rsp, m0_readdatavalid, m1_readdatavalid});
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_write_hold();
    test_round_robin();
    test_fifo_full();
    test_interleave();
    test_unexpected();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
